// File: rtl/playback_if.sv
// Transport control pulses in, beat/tone/status out.
// The sequencer uses the slave side; the controller uses the master side.
interface playback_if;
    logic        play;
    logic        stop;
    logic        speedup;
    logic        speeddown;
    logic [11:0] ibeat;
    logic        beat_tick;
    logic        en;
    logic        playing;
    logic [1:0]  speed;
    logic [1:0]  state;

    modport master (
        output play, stop, speedup, speeddown,
        input  ibeat, beat_tick, en, playing, speed, state
    );

    modport slave (
        input  play, stop, speedup, speeddown,
        output ibeat, beat_tick, en, playing, speed, state
    );
endinterface

// File: rtl/playback_sequencer.sv
// Play/pause/stop transport with clock-enable tempo counting.
// One tempo counter on the system clock paces the beat index.
module playback_sequencer #(
    parameter int LEN  = 64,
    parameter int LOOP = 1,
    parameter int DIV0 = 20000000,
    parameter int DIV1 = 10000000,
    parameter int DIV2 = 5000000,
    parameter int GAP  = 500000,
    parameter int CW   = 25
) (
    input  logic       clk,
    input  logic       rst,
    playback_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [CW-1:0] D0_LAST = CW'(DIV0 - 1);
    localparam logic [CW-1:0] D1_LAST = CW'(DIV1 - 1);
    localparam logic [CW-1:0] D2_LAST = CW'(DIV2 - 1);
    localparam logic [CW-1:0] D0_ON   = CW'(DIV0 - GAP);
    localparam logic [CW-1:0] D1_ON   = CW'(DIV1 - GAP);
    localparam logic [CW-1:0] D2_ON   = CW'(DIV2 - GAP);
    localparam logic [11:0]   LAST_B  = 12'(LEN - 1);

    state_t      st;
    logic [CW-1:0] cnt;
    logic [11:0] ibeat_q;
    logic [1:0]  speed_q;
    logic        tick_q;

    logic [CW-1:0] div_last;
    logic [CW-1:0] on_lim;
    logic        up_ok;
    logic        dn_ok;
    logic        spd_chg;
    logic        at_beat;
    logic        at_end;

    always_comb begin
        div_last = D1_LAST;
        on_lim   = D1_ON;
        case (speed_q)
            2'd0: begin
                div_last = D0_LAST;
                on_lim   = D0_ON;
            end
            2'd2: begin
                div_last = D2_LAST;
                on_lim   = D2_ON;
            end
            default: begin
                div_last = D1_LAST;
                on_lim   = D1_ON;
            end
        endcase
    end

    assign up_ok   = bus.speedup & ~bus.speeddown & (speed_q != 2'd2);
    assign dn_ok   = bus.speeddown & ~bus.speedup & (speed_q != 2'd0);
    assign spd_chg = up_ok | dn_ok;
    assign at_beat = (cnt == div_last);
    assign at_end  = (ibeat_q == LAST_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            cnt     <= '0;
            ibeat_q <= '0;
            speed_q <= 2'd1;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;

            if (up_ok)
                speed_q <= speed_q + 2'd1;
            else if (dn_ok)
                speed_q <= speed_q - 2'd1;

            case (st)
                IDLE: begin
                    cnt     <= '0;
                    ibeat_q <= '0;
                    if (bus.play)
                        st <= PLAY;
                end

                PLAY: begin
                    if (bus.stop) begin
                        st      <= IDLE;
                        cnt     <= '0;
                        ibeat_q <= '0;
                    end else if (bus.play) begin
                        st <= PAUSE;
                        if (spd_chg)
                            cnt <= '0;
                    end else begin
                        if (at_beat) begin
                            tick_q <= 1'b1;
                            cnt    <= '0;
                            if (at_end) begin
                                ibeat_q <= '0;
                                if (LOOP == 0)
                                    st <= IDLE;
                            end else begin
                                ibeat_q <= ibeat_q + 12'd1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                        // a new tempo restarts the beat so cnt stays below DIV-1
                        if (spd_chg)
                            cnt <= '0;
                    end
                end

                PAUSE: begin
                    if (bus.stop) begin
                        st      <= IDLE;
                        cnt     <= '0;
                        ibeat_q <= '0;
                    end else begin
                        if (bus.play)
                            st <= PLAY;
                        if (spd_chg)
                            cnt <= '0;
                    end
                end

                default: begin
                    st      <= IDLE;
                    cnt     <= '0;
                    ibeat_q <= '0;
                end
            endcase
        end
    end

    assign bus.ibeat     = ibeat_q;
    assign bus.beat_tick = tick_q;
    assign bus.speed     = speed_q;
    assign bus.state     = st;
    assign bus.playing   = (st == PLAY);
    assign bus.en        = (st == PLAY) && (cnt < on_lim);

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: LOOP=1 and LOOP=0 instances
// driven together and compared against a behavioural model.
module tb_playback_sequencer;

    localparam int LEN = 4;
    localparam int GAP = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic play = 1'b0;
    logic stop = 1'b0;
    logic up = 1'b0;
    logic dn = 1'b0;

    int total = 0;
    int bad = 0;

    playback_if ifa ();
    playback_if ifb ();

    assign ifa.play = play;
    assign ifa.stop = stop;
    assign ifa.speedup = up;
    assign ifa.speeddown = dn;
    assign ifb.play = play;
    assign ifb.stop = stop;
    assign ifb.speedup = up;
    assign ifb.speeddown = dn;

    playback_sequencer #(
        .LEN(LEN), .LOOP(1), .DIV0(8), .DIV1(4),
        .DIV2(2), .GAP(GAP), .CW(25)
    ) dut_loop (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );

    playback_sequencer #(
        .LEN(LEN), .LOOP(0), .DIV0(8), .DIV1(4),
        .DIV2(2), .GAP(GAP), .CW(25)
    ) dut_once (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model: transport state, position in beat, beat, tempo.
    int divs [3] = '{8, 4, 2};
    int loops [2] = '{1, 0};
    int m_st [2];
    int m_cnt [2];
    int m_ib [2];
    int m_sp [2];
    bit m_tick [2];

    task automatic model_edge(bit r, bit p, bit s, bit u, bit d);
        for (int k = 0; k < 2; k++) begin
            int nsp;
            int period;
            bit chg;
            if (r) begin
                m_st[k] = 0; m_cnt[k] = 0; m_ib[k] = 0;
                m_sp[k] = 1; m_tick[k] = 0;
                continue;
            end
            period = divs[m_sp[k]];
            nsp = m_sp[k];
            if (u && !d) nsp = (m_sp[k] + 1 > 2) ? 2 : m_sp[k] + 1;
            if (d && !u) nsp = (m_sp[k] - 1 < 0) ? 0 : m_sp[k] - 1;
            chg = (nsp != m_sp[k]);
            m_tick[k] = 0;
            if (m_st[k] == 0) begin
                if (p) m_st[k] = 1;
            end else if (s) begin
                m_st[k] = 0; m_cnt[k] = 0; m_ib[k] = 0;
            end else if (m_st[k] == 2) begin
                if (p) m_st[k] = 1;
                if (chg) m_cnt[k] = 0;
            end else if (p) begin
                m_st[k] = 2;
                if (chg) m_cnt[k] = 0;
            end else begin
                m_cnt[k] = (m_cnt[k] + 1) % period;
                if (m_cnt[k] == 0) begin
                    m_tick[k] = 1;
                    m_ib[k] = (m_ib[k] + 1) % LEN;
                    if (m_ib[k] == 0 && loops[k] == 0) m_st[k] = 0;
                end
                if (chg) m_cnt[k] = 0;
            end
            m_sp[k] = nsp;
        end
    endtask

    task automatic step(bit p, bit s, bit u, bit d);
        play = p; stop = s; up = u; dn = d;
        @(posedge clk);
        model_edge(rst, p, s, u, d);
        @(negedge clk);
        play = 0; stop = 0; up = 0; dn = 0;
    endtask

    function automatic logic [18:0] obs(int k);
        if (k == 0)
            return {ifa.ibeat, ifa.beat_tick, ifa.en,
                    ifa.playing, ifa.speed, ifa.state};
        return {ifb.ibeat, ifb.beat_tick, ifb.en,
                ifb.playing, ifb.speed, ifb.state};
    endfunction

    function automatic logic [18:0] expv(int k);
        logic e;
        e = (m_st[k] == 1) && (m_cnt[k] < divs[m_sp[k]] - GAP);
        return {12'(m_ib[k]), m_tick[k], e, m_st[k] == 1,
                2'(m_sp[k]), 2'(m_st[k])};
    endfunction

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            step(1, 0, 0, 0);
            total++;
            if ({ifa.state, ifa.ibeat, ifa.speed, ifa.en, ifa.beat_tick}
                !== {2'd0, 12'd0, 2'd1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_hold: got st=%0d ib=%0d sp=%0d en=%b tk=%b need 0/0/1/0/0",
                         ifa.state, ifa.ibeat, ifa.speed, ifa.en, ifa.beat_tick);
            end
        end
        rst = 0;
        step(0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs(k) !== expv(k) || obs(k) !== {12'd0, 5'b00001, 2'd0}) begin
                bad++;
                $display("FAIL reset_after dut%0d: got %h need %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_basic_loop();
        int ticks;
        int en_lo;
        ticks = 0;
        en_lo = 0;
        step(1, 0, 0, 0);
        total++;
        if (ifa.state !== 2'd1) begin
            bad++;
            $display("FAIL play_start: got state=%0d need 1", ifa.state);
        end
        for (int i = 0; i < 16; i++) begin
            if (!ifa.en) en_lo++;
            step(0, 0, 0, 0);
            if (ifa.beat_tick) ticks++;
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL basic dut%0d cyc%0d: got %h need %h", k, i, obs(k), expv(k));
                end
            end
        end
        total++;
        if (ticks != 4 || en_lo != 4 || ifa.ibeat !== 12'd0) begin
            bad++;
            $display("FAIL loop_wrap: got ticks=%0d enlow=%0d ib=%0d need 4/4/0",
                     ticks, en_lo, ifa.ibeat);
        end
        step(0, 1, 0, 0);
    endtask

    task automatic test_pause();
        int n;
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        total++;
        if (ifa.ibeat !== 12'd1 || m_cnt[0] != 2) begin
            bad++;
            $display("FAIL pause_setup: got ib=%0d need 1", ifa.ibeat);
        end
        step(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            total++;
            if ({ifa.state, ifa.ibeat, ifa.en, ifa.beat_tick}
                !== {2'd2, 12'd1, 1'b0, 1'b0} || obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL pause_hold cyc%0d: got st=%0d ib=%0d en=%b tk=%b need 2/1/0/0",
                         i, ifa.state, ifa.ibeat, ifa.en, ifa.beat_tick);
            end
        end
        step(1, 0, 0, 0);
        n = -1;
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 0, 0);
            if (ifa.beat_tick) begin
                n = i;
                break;
            end
        end
        total++;
        if (n != 2 || ifa.ibeat !== 12'd2) begin
            bad++;
            $display("FAIL resume: got tick after %0d ib=%0d need 2/2", n, ifa.ibeat);
        end
    endtask

    task automatic tick_gap(output int n);
        int first;
        first = -1;
        n = -1;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0);
            if (ifa.beat_tick) begin
                if (first < 0) first = i;
                else begin
                    n = i - first;
                    break;
                end
            end
        end
    endtask

    task automatic test_speed();
        int n;
        int exp_sp [3] = '{2, 2, 2};
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0);
            total++;
            if (ifa.speed !== 2'(exp_sp[i]) || obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL speedup%0d: got sp=%0d need %0d", i, ifa.speed, exp_sp[i]);
            end
        end
        tick_gap(n);
        total++;
        if (n != 2) begin
            bad++;
            $display("FAIL fast_period: got %0d need 2", n);
        end
        exp_sp = '{1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1);
            total++;
            if (ifa.speed !== 2'(exp_sp[i]) || obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL speeddown%0d: got sp=%0d need %0d", i, ifa.speed, exp_sp[i]);
            end
        end
        tick_gap(n);
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL slow_period: got %0d need 8", n);
        end
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (ifa.speed !== 2'd0 || obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL up_dn cyc%0d: got %h need %h", i, obs(0), expv(0));
            end
            step(0, 0, 0, 0);
        end
    endtask

    task automatic test_stop();
        int guard;
        step(0, 0, 1, 0);
        guard = 0;
        while (ifa.ibeat !== 12'd2 && guard < 40) begin
            step(0, 0, 0, 0);
            guard++;
        end
        step(1, 1, 0, 0);
        total++;
        if ({ifa.state, ifa.ibeat, ifa.beat_tick, ifa.en}
            !== {2'd0, 12'd0, 1'b0, 1'b0} || obs(0) !== expv(0)) begin
            bad++;
            $display("FAIL stop_prio: got st=%0d ib=%0d tk=%b en=%b need 0/0/0/0",
                     ifa.state, ifa.ibeat, ifa.beat_tick, ifa.en);
        end
    endtask

    task automatic test_end_song();
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 0, 0, 0);
        total++;
        if (ifb.state !== 2'd1 || ifb.ibeat !== 12'd3) begin
            bad++;
            $display("FAIL pre_end: got st=%0d ib=%0d need 1/3", ifb.state, ifb.ibeat);
        end
        step(0, 0, 0, 0);
        total++;
        if ({ifb.ibeat, ifb.beat_tick, ifb.state} !== {12'd0, 1'b1, 2'd0}
            || obs(1) !== expv(1)) begin
            bad++;
            $display("FAIL song_end: got ib=%0d tk=%b st=%0d need 0/1/0",
                     ifb.ibeat, ifb.beat_tick, ifb.state);
        end
        step(1, 0, 0, 0);
        total++;
        if (ifb.state !== 2'd1 || ifb.ibeat !== 12'd0 || obs(1) !== expv(1)) begin
            bad++;
            $display("FAIL restart: got st=%0d ib=%0d need 1/0", ifb.state, ifb.ibeat);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL random dut%0d cyc%0d: got %h need %h", k, i, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_loop();
        test_pause();
        test_speed();
        test_stop();
        test_end_song();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
